// File: rtl/uart_mem_loader.sv
// Serial boot loader: UART RX -> command parser -> 16-bit memory writes, CPU reset control, ACK/NAK replies.
// Optional macro LOADER_CHECKSUM_EN adds an XOR checksum byte to the 'G' (run) command.
module uart_mem_loader #(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        err_count
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TMO_CYCLES   = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int TMO_W        = $clog2(TMO_CYCLES + 1);

  localparam logic [1:0] RX_WAIT  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] P_IDLE  = 3'd0;
  localparam logic [2:0] P_A_HI  = 3'd1;
  localparam logic [2:0] P_A_LO  = 3'd2;
  localparam logic [2:0] P_D_HI  = 3'd3;
  localparam logic [2:0] P_D_LO  = 3'd4;
  localparam logic [2:0] P_WRITE = 3'd5;
  localparam logic [2:0] P_RESP  = 3'd6;
  localparam logic [2:0] P_CSUM  = 3'd7;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  // ---------------- receiver ----------------
  logic             rx_meta, rx_sync, rx_s, rx_prev;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             byte_valid;
  logic             frame_err;

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_WAIT;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_s       <= rx_sync;
      rx_prev    <= rx_s;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_WAIT: begin
          if (rx_prev && !rx_s) begin
            rx_state <= RX_START;
            bit_cnt  <= '0;
          end
        end
        RX_START: begin
          // Mid-bit recheck rejects short low glitches silently.
          if (bit_cnt == CNT_W'(HALF_BIT - 1)) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_state <= rx_s ? RX_WAIT : RX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            bit_cnt  <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          if (bit_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            bit_cnt    <= '0;
            rx_state   <= RX_WAIT;
            byte_valid <= rx_s;
            frame_err  <= !rx_s;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- parser ----------------
  logic [2:0]       p_state;
  logic [7:0]       a_hi, a_lo, d_hi;
  logic             hold_valid;
  logic [7:0]       hold_data;
  logic [TMO_W-1:0] tmo_cnt;
  logic             payload_state, accept_state, in_valid, overrun, tmo_hit, proto_err;
  logic [7:0]       in_byte;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  // NOTE: each always_comb output gets a default first so no path infers a latch.
  always_comb begin
    payload_state = (p_state == P_A_HI) || (p_state == P_A_LO) ||
                    (p_state == P_D_HI) || (p_state == P_D_LO);
`ifdef LOADER_CHECKSUM_EN
    payload_state = payload_state || (p_state == P_CSUM);
`endif
    accept_state = payload_state || (p_state == P_IDLE);
    // The held byte is older than any byte arriving this cycle, so it goes first.
    in_byte   = hold_valid ? hold_data : rx_shift;
    in_valid  = accept_state && (hold_valid || byte_valid);
    overrun   = !accept_state && byte_valid && hold_valid;
    tmo_hit   = payload_state && !in_valid && (tmo_cnt == TMO_W'(TMO_CYCLES - 1));
    proto_err = 1'b0;
    if (p_state == P_IDLE && in_valid &&
        in_byte != CMD_W && in_byte != CMD_G && in_byte != CMD_H)
      proto_err = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    if (p_state == P_CSUM && in_valid && in_byte != csum) proto_err = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_state    <= P_IDLE;
      a_hi       <= '0;
      a_lo       <= '0;
      d_hi       <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      tmo_cnt    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_reset  <= 1'b1;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      err_count  <= '0;
    end else begin
      if (accept_state) begin
        if (hold_valid) begin
          hold_valid <= byte_valid;
          hold_data  <= rx_shift;
        end
      end else if (byte_valid && !hold_valid) begin
        hold_valid <= 1'b1;
        hold_data  <= rx_shift;
      end

      if (!payload_state || in_valid) tmo_cnt <= '0;
      else                            tmo_cnt <= tmo_cnt + 1'b1;

      if ((frame_err || overrun || tmo_hit || proto_err) && err_count != 8'hFF)
        err_count <= err_count + 8'd1;

      case (p_state)
        P_IDLE: begin
          if (in_valid) begin
            tx_valid <= 1'b1;
            p_state  <= P_RESP;
            case (in_byte)
              CMD_W: begin
                tx_valid <= 1'b0;
                p_state  <= P_A_HI;
              end
              CMD_G: begin
`ifdef LOADER_CHECKSUM_EN
                tx_valid <= 1'b0;
                p_state  <= P_CSUM;
`else
                cpu_reset <= 1'b0;
                tx_data   <= ACK;
`endif
              end
              CMD_H: begin
                cpu_reset <= 1'b1;
                tx_data   <= ACK;
              end
              default: tx_data <= NAK;
            endcase
          end
        end
        P_A_HI: if (in_valid) begin a_hi <= in_byte; p_state <= P_A_LO; end
        P_A_LO: if (in_valid) begin a_lo <= in_byte; p_state <= P_D_HI; end
        P_D_HI: if (in_valid) begin d_hi <= in_byte; p_state <= P_D_LO; end
        P_D_LO: begin
          if (in_valid) begin
            if (cpu_reset) begin
              mem_addr  <= ADDR_W'({a_hi, a_lo});
              mem_wdata <= {d_hi, in_byte};
              mem_we    <= 1'b1;
              p_state   <= P_WRITE;
            end else begin
              // CPU running: payload is consumed but memory is left untouched.
              tx_data  <= NAK;
              tx_valid <= 1'b1;
              p_state  <= P_RESP;
            end
          end
        end
        P_WRITE: begin
          mem_we   <= 1'b0;
          tx_data  <= ACK;
          tx_valid <= 1'b1;
          p_state  <= P_RESP;
        end
        P_RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            p_state  <= P_IDLE;
          end
        end
        default: begin
`ifdef LOADER_CHECKSUM_EN
          if (in_valid) begin
            tx_valid <= 1'b1;
            p_state  <= P_RESP;
            if (in_byte == csum) begin
              cpu_reset <= 1'b0;
              tx_data   <= ACK;
            end else begin
              tx_data <= NAK;
            end
          end
`else
          p_state <= P_IDLE;
`endif
        end
      endcase

      if (tmo_hit) p_state <= P_IDLE;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Folds only payloads of writes that actually land in memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
    end else if (p_state == P_CSUM && in_valid && in_byte == csum) begin
      csum <= '0;
    end else if (in_valid && cpu_reset &&
                 (p_state == P_A_HI || p_state == P_A_LO ||
                  p_state == P_D_HI || p_state == P_D_LO)) begin
      csum <= csum ^ in_byte;
    end
  end
`endif

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed self-checking bench for uart_mem_loader (default build, 115200 baud at 12 MHz).
module tb_uart_mem_loader;

  localparam int CPB = 12000000 / 115200;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_reset;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  int          we_cnt  = 0;
  logic        we_prev = 1'b0;
  logic        we_wide = 1'b0;
  logic [11:0] last_addr = '0;
  logic [15:0] last_data = '0;
  int          tx_cnt  = 0;
  logic [7:0]  last_tx = '0;

  uart_mem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Observe write strobes and accepted response bytes away from the active edge.
  always @(negedge clk) begin
    we_prev <= mem_we;
    if (mem_we) begin
      we_cnt    <= we_cnt + 1;
      last_addr <= mem_addr;
      last_data <= mem_wdata;
      if (we_prev) we_wide <= 1'b1;
    end
    if (tx_valid && tx_ready) begin
      tx_cnt  <= tx_cnt + 1;
      last_tx <= tx_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_bits(input int n);
    repeat (n * CPB) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk); #1 rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx = stop;
    repeat (CPB) @(posedge clk);
    #1 rx = 1'b1;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_w(input logic [7:0] ah, input logic [7:0] al,
                        input logic [7:0] dh, input logic [7:0] dl);
    send_byte(8'h57, 1'b1);
    send_byte(ah, 1'b1);
    send_byte(al, 1'b1);
    send_byte(dh, 1'b1);
    send_byte(dl, 1'b1);
  endtask

  task automatic wait_tx(input int target);
    int i = 0;
    while (tx_cnt < target && i < 5000) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    check("tx_count", tx_cnt, target);
  endtask

  task automatic wait_we(input int target);
    int i = 0;
    while (we_cnt < target && i < 5000) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    check("we_count", we_cnt, target);
  endtask

  initial begin
    rst      = 1'b1;
    rx       = 1'b1;
    tx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mem_we",    mem_we,    1'b0);
    check("rst_mem_addr",  mem_addr,  12'h000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_tx_valid",  tx_valid,  1'b0);
    check("rst_tx_data",   tx_data,   8'h00);
    check("rst_err_count", err_count, 8'h00);
    idle_bits(2);

    // Basic write.
    send_w(8'h00, 8'h10, 8'hBE, 8'hEF);
    wait_tx(1);
    check("w1_we_count", we_cnt,    1);
    check("w1_addr",     last_addr, 12'h010);
    check("w1_data",     last_data, 16'hBEEF);
    check("w1_resp",     last_tx,   8'h06);
    check("w1_cpu_rst",  cpu_reset, 1'b1);
    check("w1_one_cyc",  we_wide,   1'b0);

    // Upper address bits masked.
    send_w(8'hF1, 8'h23, 8'h12, 8'h34);
    wait_tx(2);
    check("w2_addr", last_addr, 12'h123);
    check("w2_data", last_data, 16'h1234);
    check("w2_resp", last_tx,   8'h06);

    // Run, write refused while running, halt.
    send_byte(8'h47, 1'b1);
    wait_tx(3);
    check("g_resp",    last_tx,   8'h06);
    check("g_cpu_rst", cpu_reset, 1'b0);
    send_w(8'h00, 8'h20, 8'hAA, 8'h55);
    wait_tx(4);
    check("wrun_resp", last_tx,   8'h15);
    check("wrun_no_we", we_cnt,   2);
    check("wrun_err",  err_count, 8'h00);
    send_byte(8'h48, 1'b1);
    wait_tx(5);
    check("h_resp",    last_tx,   8'h06);
    check("h_cpu_rst", cpu_reset, 1'b1);

    // Framing error drops the byte; short glitch is ignored.
    send_byte(8'h41, 1'b0);
    idle_bits(3);
    check("frame_err",   err_count, 8'h01);
    check("frame_no_tx", tx_cnt,    5);
    @(posedge clk); #1 rx = 1'b0;
    repeat (10) @(posedge clk);
    #1 rx = 1'b1;
    idle_bits(3);
    check("glitch_err",   err_count, 8'h01);
    check("glitch_no_tx", tx_cnt,    5);

    // Mid-command timeout, then a clean write.
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    idle_bits(34);
    check("tmo_err",   err_count, 8'h02);
    check("tmo_no_tx", tx_cnt,    5);
    send_w(8'h00, 8'h30, 8'hCA, 8'hFE);
    wait_tx(6);
    check("tmo_w_addr", last_addr, 12'h030);
    check("tmo_w_data", last_data, 16'hCAFE);
    check("tmo_w_resp", last_tx,   8'h06);

    // Back-pressure: one byte buffered, next one overruns.
    @(posedge clk); #1 tx_ready = 1'b0;
    send_w(8'h00, 8'h40, 8'h56, 8'h78);
    wait_we(4);
    send_byte(8'h47, 1'b1);
    send_byte(8'h57, 1'b1);
    idle_bits(1);
    check("ovr_err",      err_count, 8'h03);
    check("ovr_tx_valid", tx_valid,  1'b1);
    check("ovr_tx_data",  tx_data,   8'h06);
    check("ovr_cpu_rst",  cpu_reset, 1'b1);
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_tx(8);
    check("held_g_resp",    last_tx,   8'h06);
    check("held_g_cpu_rst", cpu_reset, 1'b0);
    idle_bits(2);
    check("ack_once",  tx_cnt,   8);
    check("resp_idle", tx_valid, 1'b0);
    check("final_err", err_count, 8'h03);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
